// File: rtl/tt_um_mau_top_4b.sv
// rtl/tt_um_mau_top_4b.sv - 4-bit multi-function arithmetic unit with MAC accumulator
// Single-cycle datapath feeding registered result/flag/zero; done pulses one cycle per accepted op.
module tt_um_mau_top_4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] a, b, op;
  logic       start, accept;
  logic       unused_bits;

  logic [7:0] result_q, result_d;
  logic [7:0] acc_q, acc_d;
  logic       flag_q, flag_d;
  logic       zero_q, zero_d;
  logic       done_q;

  logic [4:0]  add_sum;
  logic [7:0]  prod;
  logic [7:0]  sqr;
  logic [14:0] shl_full;
  logic [3:0]  shr_res, shr_mask;
  logic [8:0]  mac_sum;

  assign a           = ui_in[3:0];
  assign b           = ui_in[7:4];
  assign op          = uio_in[3:0];
  assign start       = uio_in[4];
  assign unused_bits = &uio_in[7:5];
  // rst_n is an active-high reset despite its name; it also blocks acceptance.
  assign accept      = start & ena & ~rst_n;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign prod     = {4'b0, a} * {4'b0, b};
  assign sqr      = {4'b0, a} * {4'b0, a};
  assign shl_full = {11'b0, a} << b[2:0];
  assign shr_res  = a >> b[1:0];
  assign shr_mask = ~(4'hF << b[1:0]);
  assign mac_sum  = {1'b0, acc_q} + {1'b0, prod};

  always_comb begin
    result_d = 8'h00;
    flag_d   = 1'b0;
    acc_d    = acc_q;
    case (op)
      4'd0: begin
        result_d = {3'b0, add_sum};
        flag_d   = add_sum[4];
      end
      4'd1: begin
        result_d = {4'b0, a - b};
        flag_d   = (a < b);
      end
      4'd2:  result_d = prod;
      4'd3:  result_d = {4'b0, a & b};
      4'd4:  result_d = {4'b0, a | b};
      4'd5:  result_d = {4'b0, a ^ b};
      4'd6:  result_d = {4'b0, ~a};
      4'd7: begin
        result_d = shl_full[7:0];
        flag_d   = |shl_full[14:8];
      end
      4'd8: begin
        result_d = {4'b0, shr_res};
        flag_d   = |(a & shr_mask);
      end
      4'd9: begin
        result_d = {4'b0, (a < b) ? a : b};
        flag_d   = (a == b);
      end
      4'd10: begin
        result_d = {4'b0, (a > b) ? a : b};
        flag_d   = (a == b);
      end
      4'd11: result_d = {5'b0, (a < b), (a == b), (a > b)};
      4'd12: begin
        if (b == 4'd0) begin
          result_d = 8'hFF;
          flag_d   = 1'b1;
        end else begin
          result_d = {a / b, a % b};
        end
      end
      4'd13: result_d = sqr;
      4'd14: begin
        acc_d    = mac_sum[7:0];
        result_d = mac_sum[7:0];
        flag_d   = mac_sum[8];
      end
      default: acc_d = 8'h00;
    endcase
    zero_d = (result_d == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_q <= 8'h00;
      acc_q    <= 8'h00;
      flag_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= accept;
      if (accept) begin
        result_q <= result_d;
        acc_q    <= acc_d;
        flag_q   <= flag_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign uo_out  = result_q;
  assign uio_out = {done_q, flag_q, zero_q, 5'b0};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_mau_top_4b.sv
// tb/tb_tt_um_mau_top_4b.sv - self-checking bench for tt_um_mau_top_4b
// Directed vector table, hand-written corner sequences, then random ops against an arithmetic model.
module tb_tt_um_mau_top_4b;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_mau_top_4b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic       flag;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input int res, input int flg, input int zro, input int dn);
    check({name, " uo_out"}, uo_out, res);
    check({name, " flag"}, uio_out[6], flg);
    check({name, " zero"}, uio_out[5], zro);
    check({name, " done"}, uio_out[7], dn);
    check({name, " uio_out low"}, uio_out[4:0], 0);
    check({name, " uio_oe"}, uio_oe, 8'hE0);
  endtask

  // One cycle with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cycle(input int a, input int b, input int op, input bit st, input bit en, input bit rs);
    ui_in  = {b[3:0], a[3:0]};
    uio_in = {3'b101, st, op[3:0]};
    ena    = en;
    rst_n  = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int a, input int b, input int op, inout int acc,
                                output int res, output int flg);
    int t, s, d;
    flg = 0;
    case (op)
      0: begin res = a + b; flg = (res > 15); end
      1: begin res = (a - b + 16) % 16; flg = (a < b); end
      2: res = a * b;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = 15 - a;
      7: begin t = a * (1 << (b % 8)); res = t % 256; flg = (t >= 256); end
      8: begin s = b % 4; d = 1 << s; res = a / d; flg = ((a % d) != 0); end
      9: begin res = (a < b) ? a : b; flg = (a == b); end
      10: begin res = (a > b) ? a : b; flg = (a == b); end
      11: res = (a < b) * 4 + (a == b) * 2 + (a > b);
      12: begin
        if (b == 0) begin res = 255; flg = 1; end
        else res = (a / b) * 16 + (a % b);
      end
      13: res = a * a;
      14: begin t = acc + a * b; flg = (t >= 256); acc = t % 256; res = acc; end
      default: begin acc = 0; res = 0; end
    endcase
  endfunction

  initial begin
    int exp_res, exp_flg, exp_zero, exp_done, acc;
    int a, b, op;
    bit st, en, rs;

    vecs[0]  = '{4'd9,  4'd8,  4'd0,  8'h11, 1'b1};
    vecs[1]  = '{4'd3,  4'd5,  4'd1,  8'h0E, 1'b1};
    vecs[2]  = '{4'd5,  4'd5,  4'd1,  8'h00, 1'b0};
    vecs[3]  = '{4'd15, 4'd15, 4'd2,  8'hE1, 1'b0};
    vecs[4]  = '{4'd13, 4'd4,  4'd12, 8'h31, 1'b0};
    vecs[5]  = '{4'd7,  4'd0,  4'd12, 8'hFF, 1'b1};
    vecs[6]  = '{4'd0,  4'd0,  4'd15, 8'h00, 1'b0};
    vecs[7]  = '{4'd15, 4'd15, 4'd14, 8'hE1, 1'b0};
    vecs[8]  = '{4'd15, 4'd15, 4'd14, 8'hC2, 1'b1};
    vecs[9]  = '{4'd2,  4'd7,  4'd11, 8'h04, 1'b0};
    vecs[10] = '{4'd15, 4'd6,  4'd7,  8'hC0, 1'b1};
    vecs[11] = '{4'd12, 4'd10, 4'd3,  8'h08, 1'b0};
    vecs[12] = '{4'd12, 4'd10, 4'd4,  8'h0E, 1'b0};
    vecs[13] = '{4'd12, 4'd10, 4'd5,  8'h06, 1'b0};
    vecs[14] = '{4'd5,  4'd0,  4'd6,  8'h0A, 1'b0};
    vecs[15] = '{4'd11, 4'd3,  4'd8,  8'h01, 1'b1};
    vecs[16] = '{4'd8,  4'd3,  4'd8,  8'h01, 1'b0};
    vecs[17] = '{4'd9,  4'd4,  4'd9,  8'h04, 1'b0};
    vecs[18] = '{4'd9,  4'd4,  4'd10, 8'h09, 1'b0};
    vecs[19] = '{4'd6,  4'd6,  4'd9,  8'h06, 1'b1};
    vecs[20] = '{4'd13, 4'd0,  4'd13, 8'hA9, 1'b0};
    vecs[21] = '{4'd3,  4'd13, 4'd7,  8'h60, 1'b0};

    // Reset, with a start pending that must be discarded.
    cycle(1, 1, 0, 1'b1, 1'b1, 1'b1);
    check_out("reset", 0, 0, 0, 0);
    cycle(1, 1, 0, 1'b0, 1'b1, 1'b1);
    check_out("reset hold", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, 1'b1, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].flag, vecs[i].res == 0, 1);
    end

    // Idle cycle: outputs hold, done drops.
    cycle(4, 4, 2, 1'b0, 1'b1, 1'b0);
    check_out("idle hold", 8'h60, 0, 0, 0);
    // ena low: start ignored.
    cycle(3, 3, 2, 1'b1, 1'b0, 1'b0);
    check_out("ena gate", 8'h60, 0, 0, 0);

    // start held for three cycles: three consecutive completions.
    cycle(1, 2, 0, 1'b1, 1'b1, 1'b0);
    check_out("b2b 1", 8'h03, 0, 0, 1);
    cycle(4, 2, 0, 1'b1, 1'b1, 1'b0);
    check_out("b2b 2", 8'h06, 0, 0, 1);
    cycle(15, 2, 0, 1'b1, 1'b1, 1'b0);
    check_out("b2b 3", 8'h11, 1, 0, 1);

    // Reset in the middle of a MAC run, colliding with a start.
    cycle(0, 0, 15, 1'b1, 1'b1, 1'b0);
    check_out("clr", 8'h00, 0, 1, 1);
    cycle(3, 3, 14, 1'b1, 1'b1, 1'b0);
    check_out("mac 3x3", 8'h09, 0, 0, 1);
    cycle(3, 3, 14, 1'b1, 1'b1, 1'b1);
    check_out("rst over start", 8'h00, 0, 0, 0);
    cycle(1, 1, 14, 1'b1, 1'b1, 1'b0);
    check_out("mac after rst", 8'h01, 0, 0, 1);

    // Random traffic against the model, resynchronised by a reset.
    cycle(0, 0, 0, 1'b0, 1'b1, 1'b1);
    acc = 0; exp_res = 0; exp_flg = 0; exp_zero = 0; exp_done = 0;
    for (int n = 0; n < 400; n++) begin
      a  = $urandom_range(0, 15);
      b  = $urandom_range(0, 15);
      op = $urandom_range(0, 15);
      st = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 4) != 0);
      rs = ($urandom_range(0, 39) == 0);
      cycle(a, b, op, st, en, rs);
      if (rs) begin
        acc = 0; exp_res = 0; exp_flg = 0; exp_zero = 0; exp_done = 0;
      end else if (st && en) begin
        model(a, b, op, acc, exp_res, exp_flg);
        exp_zero = (exp_res == 0);
        exp_done = 1;
      end else begin
        exp_done = 0;
      end
      check_out($sformatf("rand%0d op%0d", n, op), exp_res, exp_flg, exp_zero, exp_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_mau_top_4b.md
TT_UM_MAU_TOP_4B -- requirements
Module: tt_um_mau_top_4b

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and the single rising-edge clock for all state.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and a synchronous, active-high reset (asserted = 1); the name is kept for TinyTapeout pin compatibility.
REQ-003 The port ena SHALL be an input, 1 bit wide; when ena = 1 the design is selected, and when ena = 0 start is ignored.
REQ-004 The port ui_in SHALL be an input, 8 bits wide, carrying operand A on [3:0] and operand B on [7:4], both unsigned.
REQ-005 The port uio_in SHALL be an input, 8 bits wide, carrying opcode on [3:0] and start on [4]; bits [7:5] are unused.
REQ-006 The port uo_out SHALL be an output, 8 bits wide, carrying the registered 8-bit result.
REQ-007 The port uio_out SHALL be an output, 8 bits wide: [7] = done, [6] = flag (carry/borrow/overflow/div-zero), [5] = zero, [4:0] = 0.
REQ-008 The port uio_oe SHALL be an output, 8 bits wide, tied constantly to 8'hE0.

Function
REQ-009 An operation SHALL be accepted on a rising edge where start = 1, ena = 1 and rst_n = 0.
REQ-010 Result, flag and zero SHALL update on the accepting edge and be visible in the following cycle.
REQ-011 done SHALL be high for exactly the one cycle following each accepting edge; latency is 1 cycle.
REQ-012 Back-to-back starts SHALL each complete, with no busy state.
REQ-013 Without an accepting edge, uo_out, flag and zero SHALL hold and done SHALL be 0.
REQ-014 zero SHALL be 1 when the new 8-bit result equals 0.
REQ-015 Opcodes 0-5 SHALL produce:
- 0 ADD: result = A+B, zero-extended 5-bit sum; flag = bit 4.
- 1 SUB: result = {4'b0, (A-B) mod 16}; flag = borrow (A<B).
- 2 MUL: result = A*B (8 bits); flag = 0.
- 3 AND, 4 OR, 5 XOR: result = {4'b0, A op B}; flag = 0.
REQ-016 Opcodes 6-10 SHALL produce:
- 6 NOT: result = {4'b0, ~A}; flag = 0.
- 7 SHL: result = A << B[2:0], computed in 8 bits; flag = 1 if any set bit is shifted beyond bit 7.
- 8 SHR: result = {4'b0, A >> B[1:0]}; flag = 1 if any 1 bit is shifted out.
- 9 MIN / 10 MAX: result = {4'b0, min(A,B) or max(A,B)}; flag = (A==B).
REQ-017 Opcode 11 CMP SHALL produce result = {5'b0, A<B, A==B, A>B}; flag = 0.
REQ-018 Opcode 12 DIV SHALL produce result = {A/B, A%B} (quotient in [7:4], remainder in [3:0]); if B = 0, result = 8'hFF and flag = 1.
REQ-019 Opcode 13 SQR SHALL produce result = A*A; flag = 0.
REQ-020 Opcode 14 MAC SHALL update the internal 8-bit accumulator acc := (acc + A*B) mod 256 and present the new acc as the result; flag = carry out of bit 7.
REQ-021 Opcode 15 CLR SHALL set acc = 0 and result = 0; flag = 0.
REQ-022 acc SHALL change only on MAC and CLR.
REQ-023 All arithmetic SHALL be unsigned, single-cycle and combinational before the output register.

Reset
REQ-024 While rst_n = 1 at a rising edge, uo_out, acc, done, flag and zero SHALL all become 0.
REQ-025 Reset SHALL take priority over a simultaneous start; the operation is discarded and no done is produced.
REQ-026 Reset asserted mid-MAC sequence SHALL clear acc, and the next MAC SHALL start from 0.
REQ-027 uio_oe SHALL be 8'hE0 at all times, including during reset.

Verification
REQ-028 ADD: A=9, B=8, op=0 -> next cycle uo_out = 0x11, flag = 1, done = 1 for one cycle.
REQ-029 SUB: A=3, B=5, op=1 -> uo_out = 0x0E, flag = 1; then A=5, B=5 -> uo_out = 0x00, zero = 1.
REQ-030 MUL: A=15, B=15, op=2 -> uo_out = 0xE1; DIV: A=13, B=4, op=12 -> uo_out = 0x31; DIV with B=0 -> uo_out = 0xFF, flag = 1.
REQ-031 MAC: CLR, then A=15, B=15 MAC twice -> uo_out = 0xE1, then 0xC2 with flag = 1; then rst -> next MAC of A=1, B=1 gives 0x01.
REQ-032 Gating: start = 1 with ena = 0 -> outputs hold and done = 0; start held high for 3 cycles with ena = 1 -> 3 consecutive done cycles.
REQ-033 CMP: A=2, B=7, op=11 -> uo_out = 0x04; SHL: A=15, B=6, op=7 -> uo_out = 0xC0, flag = 1.
